stage_evaluator: RTL and testbench

STAGE_EVALUATOR -- requirements
Module: stage_evaluator

---
 rtl/stage_evaluator.sv | 223 ++++++++++++++++++++++
 tb/tb_stage_evaluator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_evaluator.sv
// Evaluates one boosted-cascade stage: walks the stage's weak classifiers,
// reads each record from the cascade ROM and its eight rectangle corners from
// the integral image, then compares the accumulated sum with the stage threshold.
module stage_evaluator #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stage_start,
    input  logic [13:0] classifier_base_addr,
    input  logic [31:0] stage_threshold,
    input  logic [15:0] num_classifiers,
    input  logic [7:0]  window_x,
    input  logic [7:0]  window_y,
    output logic [13:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [12:0] ii_addr,
    input  logic [31:0] ii_data,
    output logic        busy,
    output logic        stage_done,
    output logic        stage_passed
);

    localparam int unsigned PITCH    = IMG_WIDTH + 1;
    localparam int unsigned II_WORDS = (IMG_WIDTH + 1) * (IMG_HEIGHT + 1);

    // The integral image must fit the 13-bit address port.
    if (II_WORDS > 8192) begin : g_size_check
        $error("stage_evaluator: integral image does not fit ii_addr");
    end

    typedef enum logic [2:0] {IDLE, FETCH, CORNERS, ACCUM, DONE} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [13:0] base_q, base_n;
    logic [31:0] thr_q, thr_n;
    logic [15:0] num_q, num_n;
    logic [7:0]  wx_q, wx_n, wy_q, wy_n;
    logic [31:0] rect0_q, rect0_n, rect1_q, rect1_n;
    logic [31:0] node_thr_q, node_thr_n, leaves_q, leaves_n;
    logic [31:0] s0_q, s0_n, s1_q, s1_n;
    logic [31:0] sum_q, sum_n;
    logic [15:0] k_q, k_n;
    logic [13:0] rom_addr_n;
    logic [12:0] ii_addr_n;
    logic        busy_n, done_n, passed_n;

    logic [31:0] feature, contrib, corner_term;
    logic [16:0] k_inc;
    logic [2:0]  next_corner, cap_corner;

    // Corner idx[2] selects the rectangle; idx[1:0] = A(+w,+h), B(+w), C(+h), D.
    function automatic logic [12:0] corner_addr(input logic [2:0] idx,
                                                input logic [31:0] r0,
                                                input logic [31:0] r1,
                                                input logic [7:0] wx,
                                                input logic [7:0] wy);
        logic [31:0] r, cx, cy;
        r  = idx[2] ? r1 : r0;
        cx = 32'(wx) + 32'(r[7:0])  + (idx[1] ? 32'd0 : 32'(r[23:16]));
        cy = 32'(wy) + 32'(r[15:8]) + (idx[0] ? 32'd0 : 32'(r[31:24]));
        return 13'(cy * 32'(PITCH) + cx);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            base_q       <= '0;
            thr_q        <= '0;
            num_q        <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            rect0_q      <= '0;
            rect1_q      <= '0;
            node_thr_q   <= '0;
            leaves_q     <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            sum_q        <= '0;
            k_q          <= '0;
            rom_addr     <= '0;
            ii_addr      <= '0;
            busy         <= 1'b0;
            stage_done   <= 1'b0;
            stage_passed <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            base_q       <= base_n;
            thr_q        <= thr_n;
            num_q        <= num_n;
            wx_q         <= wx_n;
            wy_q         <= wy_n;
            rect0_q      <= rect0_n;
            rect1_q      <= rect1_n;
            node_thr_q   <= node_thr_n;
            leaves_q     <= leaves_n;
            s0_q         <= s0_n;
            s1_q         <= s1_n;
            sum_q        <= sum_n;
            k_q          <= k_n;
            rom_addr     <= rom_addr_n;
            ii_addr      <= ii_addr_n;
            busy         <= busy_n;
            stage_done   <= done_n;
            stage_passed <= passed_n;
        end
    end

    // Next-state, address sequencing and accumulation.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        base_n     = base_q;
        thr_n      = thr_q;
        num_n      = num_q;
        wx_n       = wx_q;
        wy_n       = wy_q;
        rect0_n    = rect0_q;
        rect1_n    = rect1_q;
        node_thr_n = node_thr_q;
        leaves_n   = leaves_q;
        s0_n       = s0_q;
        s1_n       = s1_q;
        sum_n      = sum_q;
        k_n        = k_q;
        rom_addr_n = rom_addr;
        ii_addr_n  = ii_addr;
        done_n     = 1'b0;
        passed_n   = stage_passed;

        feature     = (s1_q << 1) - s0_q;
        contrib     = ($signed(feature) < $signed(node_thr_q))
                    ? {{16{leaves_q[31]}}, leaves_q[31:16]}
                    : {{16{leaves_q[15]}}, leaves_q[15:0]};
        k_inc       = 17'(k_q) + 17'd1;
        next_corner = 3'(cnt + 4'd1);
        cap_corner  = 3'(cnt - 4'd1);
        corner_term = (cap_corner[1] ^ cap_corner[0]) ? (32'd0 - ii_data) : ii_data;

        case (state)
            IDLE: begin
                if (stage_start) begin
                    base_n   = classifier_base_addr;
                    thr_n    = stage_threshold;
                    num_n    = num_classifiers;
                    wx_n     = window_x;
                    wy_n     = window_y;
                    sum_n    = '0;
                    k_n      = '0;
                    passed_n = 1'b0;
                    cnt_n    = '0;
                    if (num_classifiers != 16'd0) begin
                        state_n    = FETCH;
                        rom_addr_n = classifier_base_addr;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            FETCH: begin
                case (cnt)
                    4'd1:    rect0_n    = rom_data;
                    4'd2:    rect1_n    = rom_data;
                    4'd3:    node_thr_n = rom_data;
                    4'd4:    leaves_n   = rom_data;
                    default: ;
                endcase
                if (cnt < 4'd3) begin
                    rom_addr_n = rom_addr + 14'd1;
                end
                if (cnt == 4'd4) begin
                    state_n   = CORNERS;
                    cnt_n     = '0;
                    s0_n      = '0;
                    s1_n      = '0;
                    ii_addr_n = corner_addr(3'd0, rect0_q, rect1_q, wx_q, wy_q);
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CORNERS: begin
                if (cnt != 4'd0) begin
                    if (cap_corner[2]) s1_n = s1_q + corner_term;
                    else               s0_n = s0_q + corner_term;
                end
                if (cnt < 4'd7) begin
                    ii_addr_n = corner_addr(next_corner, rect0_q, rect1_q, wx_q, wy_q);
                end
                if (cnt == 4'd8) begin
                    state_n = ACCUM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ACCUM: begin
                sum_n = sum_q + contrib;
                k_n   = k_inc[15:0];
                if (k_inc < 17'(num_q)) begin
                    state_n    = FETCH;
                    cnt_n      = '0;
                    rom_addr_n = base_q + 14'(k_inc << 2);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done_n   = 1'b1;
                passed_n = ($signed(sum_q) >= $signed(thr_q));
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_stage_evaluator.sv
// Bench for stage_evaluator: ROM and integral-image memories, a pixel-level
// reference model of the stage result and timing, directed and random stages.
module tb_stage_evaluator;

    localparam int PITCH = 65;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stage_start = 1'b0;
    logic [13:0] classifier_base_addr = '0;
    logic [31:0] stage_threshold = '0;
    logic [15:0] num_classifiers = '0;
    logic [7:0]  window_x = '0;
    logic [7:0]  window_y = '0;
    logic [13:0] rom_addr;
    logic [31:0] rom_data;
    logic [12:0] ii_addr;
    logic [31:0] ii_data;
    logic        busy, stage_done, stage_passed;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom    [16384];
    logic [31:0] ii_mem [8192];
    int          pix    [64][64];

    stage_evaluator #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) dut (
        .clk(clk), .rst(rst), .stage_start(stage_start),
        .classifier_base_addr(classifier_base_addr),
        .stage_threshold(stage_threshold), .num_classifiers(num_classifiers),
        .window_x(window_x), .window_y(window_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ii_addr(ii_addr), .ii_data(ii_data),
        .busy(busy), .stage_done(stage_done), .stage_passed(stage_passed)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        ii_data  <= ii_mem[ii_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rect_sum(input int x0, input int y0, input int w, input int h);
        int s = 0;
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                s += pix[yy][xx];
        return s;
    endfunction

    // Stage sum from pixel sums directly, per classifier record.
    function automatic int model_sum(input logic [13:0] base, input int n, input int wx, input int wy);
        int sum = 0;
        for (int k = 0; k < n; k++) begin
            logic [13:0] a;
            logic [31:0] r0, r1, w2, w3;
            int s0, s1, f;
            a  = base + 14'(4 * k);
            r0 = rom[a];
            r1 = rom[14'(a + 14'd1)];
            w2 = rom[14'(a + 14'd2)];
            w3 = rom[14'(a + 14'd3)];
            s0 = rect_sum(wx + int'(r0[7:0]), wy + int'(r0[15:8]), int'(r0[23:16]), int'(r0[31:24]));
            s1 = rect_sum(wx + int'(r1[7:0]), wy + int'(r1[15:8]), int'(r1[23:16]), int'(r1[31:24]));
            f  = 2 * s1 - s0;
            if (f < int'($signed(w2))) sum += int'($signed(w3[31:16]));
            else                       sum += int'($signed(w3[15:0]));
        end
        return sum;
    endfunction

    task automatic build_ii();
        int t [65][65];
        for (int y = 0; y <= 64; y++)
            for (int x = 0; x <= 64; x++) begin
                if (x == 0 || y == 0) t[y][x] = 0;
                else t[y][x] = t[y-1][x] + t[y][x-1] - t[y-1][x-1] + pix[y-1][x-1];
                ii_mem[y * PITCH + x] = 32'(t[y][x]);
            end
    endtask

    task automatic write_cls(input logic [13:0] a,
                             input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w0, input logic [7:0] h0,
                             input logic [7:0] x1, input logic [7:0] y1, input logic [7:0] w1, input logic [7:0] h1,
                             input int nthr, input int lv, input int rv);
        rom[a]                  = {h0, w0, y0, x0};
        rom[14'(a + 14'd1)]     = {h1, w1, y1, x1};
        rom[14'(a + 14'd2)]     = 32'(nthr);
        rom[14'(a + 14'd3)]     = {16'(lv), 16'(rv)};
    endtask

    // Reference model: tracks acceptance, busy window, done pulse and result.
    logic m_active = 1'b0, m_done = 1'b0, m_passed = 1'b0;
    int   m_cnt = 0, m_n = 0, m_sum = 0, m_thr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_passed = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == 15 * m_n + 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_passed = (m_sum >= m_thr);
                end
            end else if (stage_start) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_n      = int'(num_classifiers);
                m_thr    = int'($signed(stage_threshold));
                m_sum    = model_sum(classifier_base_addr, m_n, int'(window_x), int'(window_y));
                m_passed = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_active));
        chk("stage_done", 32'(stage_done), 32'(m_done));
        chk("stage_passed", 32'(stage_passed), 32'(m_passed));
    end

    task automatic run_stage(input string nm, input int n, input int thr, input int wx, input int wy,
                             input logic [13:0] base, input logic chk_pass, input logic exp_pass,
                             input int exp_cyc, input int poke, input logic scr);
        int cycles = 0;
        @(negedge clk);
        classifier_base_addr = base;
        stage_threshold      = 32'(thr);
        num_classifiers      = 16'(n);
        window_x             = 8'(wx);
        window_y             = 8'(wy);
        stage_start          = 1'b1;
        @(negedge clk);
        stage_start = 1'b0;
        while (!stage_done && cycles < 15 * n + 30) begin
            @(negedge clk);
            cycles++;
            if (scr && cycles < 15 * n) begin
                classifier_base_addr = 14'($urandom);
                stage_threshold      = $urandom;
                num_classifiers      = 16'($urandom);
                window_x             = 8'($urandom);
                window_y             = 8'($urandom);
                stage_start          = ($urandom_range(0, 3) == 0);
            end else begin
                stage_start = (cycles == poke);
            end
        end
        stage_start = 1'b0;
        chk({nm, "_cycles"}, 32'(cycles), 32'(exp_cyc));
        if (chk_pass) chk({nm, "_passed"}, 32'(stage_passed), 32'(exp_pass));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = '0;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++) pix[y][x] = 1;
        build_ii();

        write_cls(14'd100, 0, 0, 24, 24, 0, 0, 12, 24, 0, -5, 7);
        write_cls(14'd200, 0, 0, 24, 24, 0, 0, 12, 24, 1, -5, 7);
        for (int k = 0; k < 3; k++)
            write_cls(14'(300 + 4 * k), 0, 0, 24, 24, 0, 0, 12, 24, 0, -5, 7);
        write_cls(14'd400, 0, 0, 24, 24, 0, 0, 24, 24, 0, -5, 7);

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_ii_addr", 32'(ii_addr), 32'd0);
        rst = 1'b0;

        chk("model_req035", 32'(model_sum(14'd100, 1, 0, 0)), 32'd7);
        chk("model_req036", 32'(model_sum(14'd200, 1, 0, 0)), 32'hFFFF_FFFB);
        chk("model_req037", 32'(model_sum(14'd300, 3, 0, 0)), 32'd21);

        run_stage("n0_thr0",  0, 0,  0, 0, 14'd0,   1'b1, 1'b1, 1,  -1, 1'b0);
        run_stage("n0_thr1",  0, 1,  0, 0, 14'd0,   1'b1, 1'b0, 1,  -1, 1'b0);
        run_stage("one_thr7", 1, 7,  0, 0, 14'd100, 1'b1, 1'b1, 16, -1, 1'b0);
        run_stage("one_thr8", 1, 8,  0, 0, 14'd100, 1'b1, 1'b0, 16, -1, 1'b0);
        run_stage("neg_thrm5",1, -5, 0, 0, 14'd200, 1'b1, 1'b1, 16, -1, 1'b0);
        run_stage("neg_thrm4",1, -4, 0, 0, 14'd200, 1'b1, 1'b0, 16, -1, 1'b0);
        run_stage("three_21", 3, 21, 0, 0, 14'd300, 1'b1, 1'b1, 46, 9,  1'b0);
        run_stage("three_22", 3, 22, 0, 0, 14'd300, 1'b1, 1'b0, 46, -1, 1'b0);

        // Address sequence for a window at (40,40).
        begin
            int exp_ii [4];
            int cyc;
            exp_ii[0] = 64 * 65 + 64; exp_ii[1] = 40 * 65 + 64;
            exp_ii[2] = 64 * 65 + 40; exp_ii[3] = 40 * 65 + 40;
            @(negedge clk);
            classifier_base_addr = 14'd400; stage_threshold = '0; num_classifiers = 16'd1;
            window_x = 8'd40; window_y = 8'd40; stage_start = 1'b1;
            @(negedge clk);
            stage_start = 1'b0;
            chk("rom_addr_0", 32'(rom_addr), 32'd400);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c <= 3) chk($sformatf("rom_addr_%0d", c), 32'(rom_addr), 32'(400 + c));
                if (c >= 5) chk($sformatf("ii_addr_%0d", c - 5), 32'(ii_addr), 32'(exp_ii[c-5]));
            end
            cyc = 8;
            while (!stage_done && cyc < 40) begin @(negedge clk); cyc++; end
            chk("win40_cycles", 32'(cyc), 32'd16);
        end

        // Reset during CORNERS of classifier 1, then a clean stage.
        @(negedge clk);
        classifier_base_addr = 14'd300; stage_threshold = 32'd21; num_classifiers = 16'd3;
        window_x = 8'd0; window_y = 8'd0; stage_start = 1'b1;
        @(negedge clk);
        stage_start = 1'b0;
        repeat (22) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(stage_done), 32'd0);
        chk("rst_passed", 32'(stage_passed), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_ii_addr", 32'(ii_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_stage("after_rst", 3, 21, 0, 0, 14'd300, 1'b1, 1'b1, 46, -1, 1'b0);

        // Random image, classifiers, thresholds and mid-stage input noise.
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++) pix[y][x] = int'($urandom_range(0, 3));
        build_ii();
        for (int t = 0; t < 40; t++) begin
            int n, wx, wy, s, thr;
            logic [13:0] base;
            n    = int'($urandom_range(0, 4));
            base = 14'($urandom_range(0, 16000));
            wx   = int'($urandom_range(0, 40));
            wy   = int'($urandom_range(0, 40));
            for (int k = 0; k < n; k++)
                write_cls(base + 14'(4 * k),
                          8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                          8'($urandom_range(1, 20)), 8'($urandom_range(1, 20)),
                          8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                          8'($urandom_range(1, 20)), 8'($urandom_range(1, 20)),
                          int'($urandom_range(0, 2400)) - 1200,
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768);
            s = model_sum(base, n, wx, wy);
            case ($urandom_range(0, 2))
                0:       thr = s;
                1:       thr = s + 1;
                default: thr = int'($urandom_range(0, 140000)) - 70000;
            endcase
            run_stage($sformatf("rand%0d", t), n, thr, wx, wy, base, 1'b0, 1'b0,
                      15 * n + 1, -1, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
